// File: rtl/fifo_col_lane.sv
// rtl/fifo_col_lane.sv - single-column synchronous FIFO with combinational head word
module fifo_col_lane #(
    parameter int bw    = 4,
    parameter int depth = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [bw-1:0] din,
    input  logic          pop,
    output logic [bw-1:0] dout,
    output logic          empty,
    output logic          full
);
    localparam int ptr_w = $clog2(depth);
    localparam logic [ptr_w:0] cnt_max = (ptr_w+1)'(depth);

    logic [bw-1:0]    mem [depth];
    logic [ptr_w-1:0] wptr;
    logic [ptr_w-1:0] rptr;
    logic [ptr_w:0]   cnt;

    // Storage is deliberately left uncleared by reset; only pointers/count matter.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout  = mem[rptr];
    assign empty = (cnt == '0);
    assign full  = (cnt == cnt_max);
endmodule

// File: rtl/ofifo_col.sv
// rtl/ofifo_col.sv - per-column psum FIFOs releasing one aligned row per pop, zero when idle
module ofifo_col #(
    parameter int bw    = 4,
    parameter int col   = 8,
    parameter int depth = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [col-1:0]    wr,
    input  logic [bw*col-1:0] in,
    input  logic              rd,
    output logic [bw*col-1:0] out,
    output logic              out_valid,
    output logic              o_valid,
    output logic              o_full,
    output logic              o_ready,
    output logic              overflow
);
    logic [col-1:0]    lane_empty;
    logic [col-1:0]    lane_full;
    logic [col-1:0]    accept;
    logic [bw*col-1:0] head_row;
    logic              pop;

    assign o_valid = ~|lane_empty;
    assign o_full  = |lane_full;
    assign o_ready = ~o_full;
    assign pop     = rd & o_valid;

    // A full lane still accepts a write when the same cycle pops it.
    assign accept = wr & (~lane_full | {col{pop}});

    for (genvar i = 0; i < col; i++) begin : g_lane
        fifo_col_lane #(
            .bw    (bw),
            .depth (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .push  (accept[i]),
            .din   (in[bw*i +: bw]),
            .pop   (pop),
            .dout  (head_row[bw*i +: bw]),
            .empty (lane_empty[i]),
            .full  (lane_full[i])
        );
    end

    // Idle cycles drive zero so downstream accumulators add nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (pop) begin
            out       <= head_row;
            out_valid <= 1'b1;
        end else begin
            out       <= '0;
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (|(wr & ~accept)) begin
            overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ofifo_col.sv
// tb/tb_ofifo_col.sv - scoreboard bench for ofifo_col with directed vectors
module tb_ofifo_col;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  wr;
    logic [31:0] in;
    logic        rd;
    logic [31:0] out;
    logic        out_valid;
    logic        o_valid;
    logic        o_full;
    logic        o_ready;
    logic        overflow;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;
    logic [31:0] exp_q[$];

    ofifo_col #(.bw(4), .col(8), .depth(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr),
        .in        (in),
        .rd        (rd),
        .out       (out),
        .out_valid (out_valid),
        .o_valid   (o_valid),
        .o_full    (o_full),
        .o_ready   (o_ready),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares every presented row against the scoreboard; idle must be zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_row: got %h expected no out_valid", out);
                end else begin
                    chk("row", out, exp_q.pop_front());
                end
            end else begin
                chk("idle_zero", out, 32'h0);
            end
        end
    end

    task automatic step(input logic [7:0] w, input logic [31:0] d, input logic r);
        wr = w;
        in = d;
        rd = r;
        @(posedge clk);
        #1;
        wr = '0;
        in = '0;
        rd = 1'b0;
    endtask

    task automatic pop_expect(input logic [31:0] row);
        exp_q.push_back(row);
        step(8'h00, 32'h0, 1'b1);
    endtask

    function automatic logic [31:0] diag_row(input int k);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'((k + i) % 16);
        end
        return r;
    endfunction

    initial begin
        reset = 1'b1;
        wr = '0;
        in = '0;
        rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;

        chk("rst_out", out, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_o_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_o_ready", {31'b0, o_ready}, 32'd1);
        chk("rst_o_full", {31'b0, o_full}, 32'd0);
        chk("rst_overflow", {31'b0, overflow}, 32'd0);

        step(8'h00, 32'h0, 1'b1);
        chk("idle_rd_o_valid", {31'b0, o_valid}, 32'd0);

        // Skewed column fill
        step(8'h01, 32'h0000_0003, 1'b0);
        chk("skew_o_valid_1", {31'b0, o_valid}, 32'd0);
        step(8'hFE, 32'h7654_3210, 1'b0);
        chk("skew_o_valid_2", {31'b0, o_valid}, 32'd1);
        pop_expect(32'h7654_3213);
        chk("skew_drained", {31'b0, o_valid}, 32'd0);
        step(8'h00, 32'h0, 1'b0);

        // Fill every column to depth
        for (int k = 0; k < 16; k++) begin
            step(8'hFF, diag_row(k), 1'b0);
            if (k == 14) chk("full_at_15", {31'b0, o_full}, 32'd0);
        end
        chk("full_o_full", {31'b0, o_full}, 32'd1);
        chk("full_o_ready", {31'b0, o_ready}, 32'd0);

        // Write plus pop on a full FIFO: write lands, count stays at depth
        exp_q.push_back(diag_row(0));
        step(8'hFF, diag_row(16), 1'b1);
        chk("wp_overflow", {31'b0, overflow}, 32'd0);
        chk("wp_o_full", {31'b0, o_full}, 32'd1);

        step(8'h01, 32'h0000_0009, 1'b0);
        chk("drop_overflow", {31'b0, overflow}, 32'd1);

        for (int k = 1; k <= 16; k++) begin
            pop_expect(diag_row(k));
        end
        chk("drain_o_valid", {31'b0, o_valid}, 32'd0);
        chk("drain_o_ready", {31'b0, o_ready}, 32'd1);
        chk("overflow_sticky", {31'b0, overflow}, 32'd1);

        reset = 1'b1;
        step(8'h00, 32'h0, 1'b0);
        reset = 1'b0;
        chk("rst2_overflow", {31'b0, overflow}, 32'd0);

        // Five buffered rows, continuous reads
        step(8'hFF, 32'h1111_1111, 1'b0);
        step(8'hFF, 32'h2222_2222, 1'b0);
        step(8'hFF, 32'h3333_3333, 1'b0);
        step(8'hFF, 32'h4444_4444, 1'b0);
        step(8'hFF, 32'h5555_5555, 1'b0);
        pop_expect(32'h1111_1111);
        pop_expect(32'h2222_2222);
        pop_expect(32'h3333_3333);
        pop_expect(32'h4444_4444);
        pop_expect(32'h5555_5555);
        chk("burst_o_valid", {31'b0, o_valid}, 32'd0);
        step(8'h00, 32'h0, 1'b1);

        // Reset with three rows buffered, rd held on the reset cycle
        step(8'hFF, 32'hAAAA_AAAA, 1'b0);
        step(8'hFF, 32'hBBBB_BBBB, 1'b0);
        step(8'hFF, 32'hCCCC_CCCC, 1'b0);
        reset = 1'b1;
        step(8'h00, 32'h0, 1'b1);
        reset = 1'b0;
        chk("rst3_o_valid", {31'b0, o_valid}, 32'd0);
        chk("rst3_out", out, 32'h0);
        step(8'hFF, 32'h9ABC_DEF0, 1'b0);
        pop_expect(32'h9ABC_DEF0);
        chk("rst3_empty", {31'b0, o_valid}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
